riscv_decode_stage: RTL

//  RV32I decode stage: instruction decode, immediate generation and the 32x32 integer register file.

---
 rtl/riscv_decode_stage.sv | 210 +++++++++++++++++++++
 1 files changed

// File: rtl/riscv_decode_stage.sv
`default_nettype none
// ============================================================================
// Module      : riscv_decode_stage
// Description : RV32I decode: control decode, immediate generation and the
//               32x32 register file with write-through from write-back.
// Revision    : 1.0 - initial release
// ============================================================================
module riscv_decode_stage #(
   parameter int XLEN      = 32,
   parameter int REG_DEPTH = 32
) (
   input  logic            i_clk,
   input  logic            i_rstn,
   input  logic [31:0]     i_instr,
   input  logic            i_wb_en,
   input  logic [4:0]      i_wb_addr,
   input  logic [XLEN-1:0] i_wb_data,
   output logic [2:0]      o_src_imm,
   output logic [1:0]      o_src_rd,
   output logic            o_src_alu_a,
   output logic            o_src_alu_b,
   output logic            o_reg_wr_en,
   output logic            o_mem_wr_en,
   output logic [3:0]      o_mem_byte_sel,
   output logic [3:0]      o_alu_ctrl,
   output logic [XLEN-1:0] o_rs1_data,
   output logic [XLEN-1:0] o_rs2_data,
   output logic [4:0]      o_rs1_addr,
   output logic [4:0]      o_rs2_addr,
   output logic [4:0]      o_rd_addr,
   output logic [2:0]      o_func3,
   output logic [XLEN-1:0] o_imm_ext,
   output logic [6:0]      o_opcode,
   output logic            o_is_load,
   output logic            o_illegal
);
   localparam logic [6:0] c_OP_LOAD   = 7'b0000011;
   localparam logic [6:0] c_OP_STORE  = 7'b0100011;
   localparam logic [6:0] c_OP_BRANCH = 7'b1100011;
   localparam logic [6:0] c_OP_JALR   = 7'b1100111;
   localparam logic [6:0] c_OP_JAL    = 7'b1101111;
   localparam logic [6:0] c_OP_IMM    = 7'b0010011;
   localparam logic [6:0] c_OP_REG    = 7'b0110011;
   localparam logic [6:0] c_OP_LUI    = 7'b0110111;
   localparam logic [6:0] c_OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] c_OP_FENCE  = 7'b0001111;
   localparam logic [6:0] c_OP_SYSTEM = 7'b1110011;

   localparam logic [2:0] c_IMM_I = 3'd0;
   localparam logic [2:0] c_IMM_S = 3'd1;
   localparam logic [2:0] c_IMM_B = 3'd2;
   localparam logic [2:0] c_IMM_U = 3'd3;
   localparam logic [2:0] c_IMM_J = 3'd4;

   logic [XLEN-1:0] r_regs [1:REG_DEPTH-1];

   logic [6:0] w_f7;
   logic [2:0] w_f3;
   logic [3:0] w_size_sel;
   logic       w_reg_wr;
   logic       w_mem_wr;
   logic       w_load;

   assign o_opcode  = i_instr[6:0];
   assign o_func3   = i_instr[14:12];
   assign o_rd_addr = i_instr[11:7];
   assign w_f3      = i_instr[14:12];
   assign w_f7      = i_instr[31:25];

   always_comb begin
      case (w_f3[1:0])
         2'b00:   w_size_sel = 4'b0001;
         2'b01:   w_size_sel = 4'b0011;
         2'b10:   w_size_sel = 4'b1111;
         default: w_size_sel = 4'b0000;
      endcase
   end

   always_comb begin
      o_src_imm      = c_IMM_I;
      o_src_rd       = 2'd0;
      o_src_alu_a    = 1'b0;
      o_src_alu_b    = 1'b0;
      o_alu_ctrl     = 4'b0000;
      o_mem_byte_sel = 4'b0000;
      o_rs1_addr     = i_instr[19:15];
      o_rs2_addr     = 5'd0;
      o_illegal      = 1'b0;
      w_reg_wr       = 1'b0;
      w_mem_wr       = 1'b0;
      w_load         = 1'b0;
      case (o_opcode)
         c_OP_LOAD: begin
            o_src_rd       = 2'd1;
            o_src_alu_b    = 1'b1;
            w_reg_wr       = 1'b1;
            w_load         = 1'b1;
            o_mem_byte_sel = w_size_sel;
            o_illegal      = (w_f3 == 3'b011) || (w_f3 == 3'b110) || (w_f3 == 3'b111);
         end
         c_OP_STORE: begin
            o_src_imm      = c_IMM_S;
            o_src_alu_b    = 1'b1;
            o_rs2_addr     = i_instr[24:20];
            w_mem_wr       = 1'b1;
            o_mem_byte_sel = w_size_sel;
            o_illegal      = (w_f3 > 3'b010);
         end
         c_OP_BRANCH: begin
            o_src_imm  = c_IMM_B;
            o_rs2_addr = i_instr[24:20];
            o_illegal  = (w_f3 == 3'b010) || (w_f3 == 3'b011);
            // Branch compare reuses the ALU: equality via SUB, ordering via SLT/SLTU
            case (w_f3[2:1])
               2'b00:   o_alu_ctrl = 4'b1000;
               2'b10:   o_alu_ctrl = 4'b0010;
               default: o_alu_ctrl = 4'b0011;
            endcase
         end
         c_OP_JALR: begin
            o_src_rd    = 2'd2;
            o_src_alu_b = 1'b1;
            w_reg_wr    = 1'b1;
            o_illegal   = (w_f3 != 3'b000);
         end
         c_OP_JAL: begin
            o_src_imm   = c_IMM_J;
            o_src_rd    = 2'd2;
            o_src_alu_a = 1'b1;
            o_src_alu_b = 1'b1;
            o_rs1_addr  = 5'd0;
            w_reg_wr    = 1'b1;
         end
         c_OP_LUI: begin
            o_src_imm   = c_IMM_U;
            o_src_rd    = 2'd3;
            o_src_alu_b = 1'b1;
            o_rs1_addr  = 5'd0;
            w_reg_wr    = 1'b1;
         end
         c_OP_AUIPC: begin
            o_src_imm   = c_IMM_U;
            o_src_alu_a = 1'b1;
            o_src_alu_b = 1'b1;
            o_rs1_addr  = 5'd0;
            w_reg_wr    = 1'b1;
         end
         c_OP_IMM: begin
            o_src_alu_b = 1'b1;
            w_reg_wr    = 1'b1;
            o_alu_ctrl  = {w_f7[5] & (w_f3 == 3'b101), w_f3};
            o_illegal   = ((w_f3 == 3'b001) && (w_f7 != 7'h00)) ||
                          ((w_f3 == 3'b101) && (w_f7 != 7'h00) && (w_f7 != 7'h20));
         end
         c_OP_REG: begin
            o_rs2_addr = i_instr[24:20];
            w_reg_wr   = 1'b1;
            o_alu_ctrl = {w_f7[5], w_f3};
            o_illegal  = ((w_f7 != 7'h00) && (w_f7 != 7'h20)) ||
                         ((w_f7 == 7'h20) && (w_f3 != 3'b000) && (w_f3 != 3'b101));
         end
         c_OP_FENCE, c_OP_SYSTEM: begin
         end
         default: o_illegal = 1'b1;
      endcase
      if (o_illegal) o_mem_byte_sel = 4'b0000;
   end

   assign o_reg_wr_en = w_reg_wr & ~o_illegal;
   assign o_mem_wr_en = w_mem_wr & ~o_illegal;
   assign o_is_load   = w_load   & ~o_illegal;

   always_comb begin
      case (o_src_imm)
         c_IMM_S: o_imm_ext = {{(XLEN-12){i_instr[31]}}, i_instr[31:25], i_instr[11:7]};
         c_IMM_B: o_imm_ext = {{(XLEN-13){i_instr[31]}}, i_instr[31], i_instr[7],
                               i_instr[30:25], i_instr[11:8], 1'b0};
         c_IMM_U: o_imm_ext = {i_instr[31:12], 12'b0};
         c_IMM_J: o_imm_ext = {{(XLEN-21){i_instr[31]}}, i_instr[31], i_instr[19:12],
                               i_instr[20], i_instr[30:21], 1'b0};
         default: o_imm_ext = {{(XLEN-12){i_instr[31]}}, i_instr[31:20]};
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) begin
         for (int k = 1; k < REG_DEPTH; k++) r_regs[k] <= '0;
      end else if (i_wb_en && (i_wb_addr != 5'd0)) begin
         r_regs[i_wb_addr] <= i_wb_data;
      end
   end

   // Write-through: a same-cycle write-back wins over the stored value
   always_comb begin
      o_rs1_data = '0;
      if (i_rstn && (o_rs1_addr != 5'd0)) begin
         if (i_wb_en && (i_wb_addr == o_rs1_addr)) o_rs1_data = i_wb_data;
         else                                       o_rs1_data = r_regs[o_rs1_addr];
      end
   end

   always_comb begin
      o_rs2_data = '0;
      if (i_rstn && (o_rs2_addr != 5'd0)) begin
         if (i_wb_en && (i_wb_addr == o_rs2_addr)) o_rs2_data = i_wb_data;
         else                                       o_rs2_data = r_regs[o_rs2_addr];
      end
   end
endmodule
`default_nettype wire
